// File: rtl/cmd_parser.sv
// Byte-oriented command parser: decodes read/write commands from a serial front end into register-file accesses.
// Optional WAIT_DATA inter-byte timeout is compiled in when CMD_PARSER_TIMEOUT_EN is defined.
module cmd_parser #(
    parameter int unsigned MAX_ADDR    = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] addr_o,
    output logic [7:0] data_o,
    output logic       wr_en_o,
    input  logic [7:0] reg_data_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WRITE,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       wr_en_q, wr_en_d;
    logic       err_q, err_d;

    logic [31:0] cmd_addr;
    logic        cmd_addr_ok;

    assign cmd_addr    = {25'd0, rx_data_i[6:0]};
    assign cmd_addr_ok = (cmd_addr < MAX_ADDR);

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        wr_en_d    = 1'b0;
        err_d      = 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
        cnt_d      = '0;
`endif

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    if (cmd_addr_ok) begin
                        addr_d  = {1'b0, rx_data_i[6:0]};
                        state_d = rx_data_i[7] ? WAIT_DATA : RD_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            WAIT_DATA: begin
                // A data byte arriving on the limit cycle still wins over the timeout.
                if (rx_valid_i) begin
                    data_d  = rx_data_i;
                    wr_en_d = 1'b1;
                    state_d = WRITE;
                end
`ifdef CMD_PARSER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            WRITE: begin
                state_d = IDLE;
                if (rx_valid_i) begin
                    err_d = 1'b1;
                end
            end

            RD_WAIT: begin
                tx_data_d  = reg_data_i;
                tx_valid_d = 1'b1;
                state_d    = RD_RESP;
                if (rx_valid_i) begin
                    err_d = 1'b1;
                end
            end

            RD_RESP: begin
                if (tx_valid_q && tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
                if (rx_valid_i) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
`ifdef CMD_PARSER_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign wr_en_o    = wr_en_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser; each task drives one scenario and checks hand-computed values.
// The timeout scenario follows whether CMD_PARSER_TIMEOUT_EN is defined for the build.
module tb_cmd_parser;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] addr_o;
    logic [7:0] data_o;
    logic       wr_en_o;
    logic [7:0] reg_data_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    // Event counters sampled on the active edge, so each counts whole cycles.
    int wr_count   = 0;
    int err_count  = 0;
    int xfer_count = 0;

    cmd_parser #(
        .MAX_ADDR   (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data_i (rx_data_i),
        .rx_valid_i(rx_valid_i),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .wr_en_o   (wr_en_o),
        .reg_data_i(reg_data_i),
        .tx_data_o (tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en_o === 1'b1) wr_count = wr_count + 1;
        if (err_o === 1'b1) err_count = err_count + 1;
        if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) xfer_count = xfer_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (addr_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=00", addr_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", data_o); end
        total++; if ({wr_en_o, tx_valid_o, err_o} !== 3'b000) begin bad++; $display("[TB] FAIL reset_strobes got=%b exp=000", {wr_en_o, tx_valid_o, err_o}); end
        total++; if (tx_data_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_txdata got=%h exp=00", tx_data_o); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int wr0 = wr_count;
        send_byte(8'h83);
        total++; if (addr_o !== 8'h03) begin bad++; $display("[TB] FAIL wr_cmd_addr got=%h exp=03", addr_o); end
        total++; if (wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL wr_early got=%b exp=0", wr_en_o); end
        send_byte(8'h5A);
        total++; if ({wr_en_o, addr_o, data_o} !== {1'b1, 8'h03, 8'h5A}) begin bad++; $display("[TB] FAIL wr_strobe got=%b/%h/%h exp=1/03/5a", wr_en_o, addr_o, data_o); end
        tick();
        total++; if ({wr_en_o, addr_o, data_o} !== {1'b0, 8'h03, 8'h5A}) begin bad++; $display("[TB] FAIL wr_after got=%b/%h/%h exp=0/03/5a", wr_en_o, addr_o, data_o); end
        total++; if (wr_count - wr0 !== 1) begin bad++; $display("[TB] FAIL wr_pulses got=%0d exp=1", wr_count - wr0); end
    endtask

    task automatic test_read();
        int x0 = xfer_count;
        reg_data_i = 8'hC3;
        tx_ready_i = 1'b0;
        send_byte(8'h02);
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_n1_valid got=%b exp=0", tx_valid_o); end
        tick();
        total++; if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hC3}) begin bad++; $display("[TB] FAIL rd_n2 got=%b/%h exp=1/c3", tx_valid_o, tx_data_o); end
        reg_data_i = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hC3}) begin bad++; $display("[TB] FAIL rd_hold%0d got=%b/%h exp=1/c3", i, tx_valid_o, tx_data_o); end
        end
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_clear got=%b exp=0", tx_valid_o); end
        tick();
        total++; if (xfer_count - x0 !== 1) begin bad++; $display("[TB] FAIL rd_xfers got=%0d exp=1", xfer_count - x0); end
    endtask

    task automatic test_invalid_addr();
        int wr0 = wr_count;
        int e0  = err_count;
        send_byte(8'h88);
        total++; if ({err_o, addr_o} !== {1'b1, 8'h02}) begin bad++; $display("[TB] FAIL inv_err got=%b/%h exp=1/02", err_o, addr_o); end
        tick();
        total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL inv_err_once got=%b exp=0", err_o); end
        send_byte(8'h81);
        total++; if ({err_o, addr_o} !== {1'b0, 8'h01}) begin bad++; $display("[TB] FAIL inv_next_cmd got=%b/%h exp=0/01", err_o, addr_o); end
        send_byte(8'h22);
        total++; if ({wr_en_o, addr_o, data_o} !== {1'b1, 8'h01, 8'h22}) begin bad++; $display("[TB] FAIL inv_next_wr got=%b/%h/%h exp=1/01/22", wr_en_o, addr_o, data_o); end
        tick();
        total++; if (wr_count - wr0 !== 1 || err_count - e0 !== 1) begin bad++; $display("[TB] FAIL inv_counts got=wr%0d/err%0d exp=wr1/err1", wr_count - wr0, err_count - e0); end
    endtask

    task automatic test_overrun();
        int x0 = xfer_count;
        reg_data_i = 8'h3C;
        tx_ready_i = 1'b0;
        send_byte(8'h04);
        tick();
        reg_data_i = 8'h00;
        send_byte(8'h99);
        total++; if ({err_o, tx_valid_o, tx_data_o} !== {1'b1, 1'b1, 8'h3C}) begin bad++; $display("[TB] FAIL ovr_resp got=%b/%b/%h exp=1/1/3c", err_o, tx_valid_o, tx_data_o); end
        total++; if (addr_o !== 8'h04) begin bad++; $display("[TB] FAIL ovr_addr got=%h exp=04", addr_o); end
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        total++; if ({err_o, tx_valid_o} !== 2'b00) begin bad++; $display("[TB] FAIL ovr_done got=%b/%b exp=0/0", err_o, tx_valid_o); end
        total++; if (xfer_count - x0 !== 1) begin bad++; $display("[TB] FAIL ovr_xfers got=%0d exp=1", xfer_count - x0); end
        // Byte during WRITE is dropped: address stays 6, no second write.
        send_byte(8'h86);
        send_byte(8'h77);
        send_byte(8'h12);
        total++; if ({err_o, wr_en_o, addr_o, data_o} !== {1'b1, 1'b0, 8'h06, 8'h77}) begin bad++; $display("[TB] FAIL ovr_write got=%b/%b/%h/%h exp=1/0/06/77", err_o, wr_en_o, addr_o, data_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int x0 = xfer_count;
        reg_data_i = 8'hA7;
        tx_ready_i = 1'b1;
        send_byte(8'h05);
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_n1 got=%b exp=0", tx_valid_o); end
        tick();
        total++; if ({tx_valid_o, tx_data_o} !== {1'b1, 8'hA7}) begin bad++; $display("[TB] FAIL b2b_n2 got=%b/%h exp=1/a7", tx_valid_o, tx_data_o); end
        tick();
        tx_ready_i = 1'b0;
        total++; if (tx_valid_o !== 1'b0 || xfer_count - x0 !== 1) begin bad++; $display("[TB] FAIL b2b_hs got=%b/%0d exp=0/1", tx_valid_o, xfer_count - x0); end
        send_byte(8'h87);
        send_byte(8'hE1);
        total++; if ({wr_en_o, addr_o, data_o} !== {1'b1, 8'h07, 8'hE1}) begin bad++; $display("[TB] FAIL b2b_wr got=%b/%h/%h exp=1/07/e1", wr_en_o, addr_o, data_o); end
        tick();
    endtask

    task automatic test_timeout();
        int wr0 = wr_count;
`ifdef CMD_PARSER_TIMEOUT_EN
        send_byte(8'h84);
        for (int i = 0; i < 15; i++) tick();
        total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL to_early got=%b exp=0", err_o); end
        tick();
        total++; if (err_o !== 1'b1 || wr_count - wr0 !== 0) begin bad++; $display("[TB] FAIL to_fire got=%b/%0d exp=1/0", err_o, wr_count - wr0); end
        send_byte(8'h82);
        total++; if ({err_o, addr_o} !== {1'b0, 8'h02}) begin bad++; $display("[TB] FAIL to_idle got=%b/%h exp=0/02", err_o, addr_o); end
        for (int i = 0; i < 15; i++) tick();
        send_byte(8'h44);
        total++; if ({wr_en_o, err_o, data_o} !== {1'b1, 1'b0, 8'h44}) begin bad++; $display("[TB] FAIL to_race got=%b/%b/%h exp=1/0/44", wr_en_o, err_o, data_o); end
`else
        send_byte(8'h84);
        for (int i = 0; i < 40; i++) tick();
        total++; if (err_o !== 1'b0 || wr_count - wr0 !== 0) begin bad++; $display("[TB] FAIL to_none got=%b/%0d exp=0/0", err_o, wr_count - wr0); end
        send_byte(8'h5B);
        total++; if ({wr_en_o, addr_o, data_o} !== {1'b1, 8'h04, 8'h5B}) begin bad++; $display("[TB] FAIL to_late_wr got=%b/%h/%h exp=1/04/5b", wr_en_o, addr_o, data_o); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        int wr0 = wr_count;
        send_byte(8'h85);
        rst_n = 1'b0;
        #1;
        total++; if ({addr_o, data_o, wr_en_o} !== {8'h00, 8'h00, 1'b0}) begin bad++; $display("[TB] FAIL rst_mid got=%h/%h/%b exp=00/00/0", addr_o, data_o, wr_en_o); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (wr_count - wr0 !== 0) begin bad++; $display("[TB] FAIL rst_no_wr got=%0d exp=0", wr_count - wr0); end
        send_byte(8'h85);
        send_byte(8'h11);
        total++; if ({wr_en_o, addr_o, data_o} !== {1'b1, 8'h05, 8'h11}) begin bad++; $display("[TB] FAIL rst_after_wr got=%b/%h/%h exp=1/05/11", wr_en_o, addr_o, data_o); end
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        reg_data_i = 8'h00;
        tx_ready_i = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_invalid_addr();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 SHALL provide parameter MAX_ADDR, default 8, number of addressable registers; command addresses at or above it are invalid.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1000, the number of idle cycles allowed between the command byte and the data byte of a write.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 SHALL have port rx_data_i, input, 8, received byte from the serial front end.
REQ-006 SHALL have port rx_valid_i, input, 1, single-cycle strobe qualifying rx_data_i.
REQ-007 SHALL have port addr_o, output, 8, register address driven to the register file.
REQ-008 SHALL have port data_o, output, 8, write data driven to the register file.
REQ-009 SHALL have port wr_en_o, output, 1, one-cycle write strobe to the register file.
REQ-010 SHALL have port reg_data_i, input, 8, read data returned by the register file for addr_o.
REQ-011 SHALL have port tx_data_o, output, 8, read-back byte to the serial front end.
REQ-012 SHALL have port tx_valid_o, output, 1, tx_data_o valid; held until accepted.
REQ-013 SHALL have port tx_ready_i, input, 1, serial front end accepts tx_data_o when high with tx_valid_o.
REQ-014 SHALL have port err_o, output, 1, one-cycle pulse on any protocol error.

Function
REQ-015 SHALL implement states IDLE, WAIT_DATA, WRITE, RD_WAIT, RD_RESP.
REQ-016 SHALL decode the command byte in IDLE as follows: bit7 = 1 means write, bit7 = 0 means read, and bits[6:0] give the address.
REQ-017 SHALL, in IDLE, on rx_valid_i with an address below MAX_ADDR, register the address into addr_o and go to WAIT_DATA for a write or RD_WAIT for a read.
REQ-018 SHALL, in IDLE, on rx_valid_i with an address at or above MAX_ADDR, pulse err_o the next cycle, stay in IDLE and leave addr_o unchanged.
REQ-019 SHALL, in WAIT_DATA, on rx_valid_i, register the byte into data_o and go to WRITE.
REQ-020 SHALL, in WRITE, hold wr_en_o high for exactly one cycle and then return to IDLE.
REQ-021 SHALL meet this write latency: if the data byte is strobed in cycle N, wr_en_o is high in cycle N+1 only, with addr_o and data_o stable that cycle.
REQ-022 SHALL, in RD_WAIT, last one cycle, capture reg_data_i into tx_data_o at its end, and go to RD_RESP.
REQ-023 SHALL meet this read latency: if the read command is strobed in cycle N, tx_valid_o rises in cycle N+2.
REQ-024 SHALL, in RD_RESP, hold tx_valid_o and tx_data_o stable until tx_valid_o and tx_ready_i are both high, then clear tx_valid_o next cycle and return to IDLE.
REQ-025 SHALL, on any rx_valid_i in WRITE, RD_WAIT or RD_RESP, discard the byte, pulse err_o, and not alter state.
REQ-026 SHALL hold addr_o and data_o at their last value between transactions.
REQ-027 SHALL, if tx_ready_i is already high when tx_valid_o rises, complete the handshake in that same cycle.

Reset
REQ-028 SHALL, while rst_n is low, immediately force state IDLE, addr_o 0, data_o 0, tx_data_o 0, wr_en_o 0, tx_valid_o 0, err_o 0 and the timeout counter 0.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction with no wr_en_o pulse, and SHALL accept a new command on the first rx_valid_i after release.

Configuration
REQ-030 SHALL compile in the WAIT_DATA inter-byte timeout when macro CMD_PARSER_TIMEOUT_EN is defined.
REQ-031 SHALL, with CMD_PARSER_TIMEOUT_EN defined, count cycles in WAIT_DATA; if the count reaches TIMEOUT_CYC without rx_valid_i, it SHALL pulse err_o, return to IDLE and clear the counter.
REQ-032 SHALL, with CMD_PARSER_TIMEOUT_EN defined, let rx_valid_i in the same cycle the limit is reached win: the write proceeds and there is no error.
REQ-033 SHALL, without CMD_PARSER_TIMEOUT_EN, contain no counter logic and wait in WAIT_DATA indefinitely.

Verification
REQ-034 Write: bytes 0x83, then 0x5A -> one wr_en_o pulse with addr_o 0x03 and data_o 0x5A, one cycle after the 0x5A strobe.
REQ-035 Read: reg_data_i tied 0xC3, byte 0x02, tx_ready_i low for 5 cycles then high -> tx_valid_o rises 2 cycles after the strobe, tx_data_o 0xC3 stable throughout, and one transfer.
REQ-036 Invalid address: byte 0x88 -> err_o pulses once, no wr_en_o, and the next byte 0x81 is treated as a command.
REQ-037 Overrun: rx_valid_i during RD_RESP -> err_o pulses, and the pending response is still delivered unchanged.
REQ-038 Timeout with the macro defined and TIMEOUT_CYC=16: byte 0x84, then silence -> err_o pulses after 16 cycles, state IDLE, no wr_en_o.
REQ-039 Reset: rst_n low one cycle after byte 0x85 -> no wr_en_o; after release, 0x85 then 0x11 -> write of 0x11 to address 5.
